// File: rtl/d_reg_universal_if.sv
// Handshake-free control/data bundle for the universal register.
// The master drives controls and data; the slave returns registered state.
interface d_reg_universal_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             carry;
  logic             zero;

  modport master (
    output en, mode, d, sin_l, sin_r,
    input  q, qbar, carry, zero
  );

  modport slave (
    input  en, mode, d, sin_l, sin_r,
    output q, qbar, carry, zero
  );
endinterface

// File: rtl/d_reg_universal.sv
// WIDTH-bit register with load, shift, rotate and count modes.
// All outputs, including qbar and zero, come straight from flops.
module d_reg_universal #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  d_reg_universal_if.slave bus
);
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_INC  = 3'b110;
  localparam logic [2:0] M_DEC  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic             r_carry;
  logic             r_zero;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_c_nxt;

  always_comb begin
    w_q_nxt = r_q;
    w_c_nxt = r_carry;
    unique case (bus.mode)
      M_HOLD: begin
        w_q_nxt = r_q;
        w_c_nxt = r_carry;
      end
      M_LOAD: begin
        w_q_nxt = bus.d;
        w_c_nxt = 1'b0;
      end
      M_SHL: begin
        w_q_nxt = {r_q[WIDTH-2:0], bus.sin_l};
        w_c_nxt = r_q[WIDTH-1];
      end
      M_SHR: begin
        w_q_nxt = {bus.sin_r, r_q[WIDTH-1:1]};
        w_c_nxt = r_q[0];
      end
      M_ROL: begin
        w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_c_nxt = r_q[WIDTH-1];
      end
      M_ROR: begin
        w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
        w_c_nxt = r_q[0];
      end
      M_INC: begin
        w_q_nxt = r_q + WIDTH'(1);
        w_c_nxt = &r_q;
      end
      M_DEC: begin
        w_q_nxt = r_q - WIDTH'(1);
        w_c_nxt = ~|r_q;
      end
      default: begin
        w_q_nxt = r_q;
        w_c_nxt = r_carry;
      end
    endcase
  end

  // qbar and zero are derived from the next value so they stay flop outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= RESET_VAL;
      r_qbar  <= ~RESET_VAL;
      r_carry <= 1'b0;
      r_zero  <= (RESET_VAL == '0);
    end else if (bus.en) begin
      r_q     <= w_q_nxt;
      r_qbar  <= ~w_q_nxt;
      r_carry <= w_c_nxt;
      r_zero  <= (w_q_nxt == '0);
    end
  end

  assign bus.q     = r_q;
  assign bus.qbar  = r_qbar;
  assign bus.carry = r_carry;
  assign bus.zero  = r_zero;
endmodule

// File: doc/d_reg_universal.md
Name: d_reg_universal

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit edge-triggered register with true and complement outputs.
- Adds synchronous reset, clock enable and eight operating modes: hold, parallel load, shift, rotate, increment, decrement.
- Sits in datapaths as a general-purpose staging, shift or count register, replacing hand-instantiated banks of D flip-flops.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 = hold everything.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial in for shift-left (enters bit 0).
- sin_r  input  1  serial in for shift-right (enters bit WIDTH-1).
- q  output  WIDTH  register value.
- qbar  output  WIDTH  registered complement; always equals ~q.
- carry  output  1  registered shifted-out / wrap flag.
- zero  output  1  registered flag, 1 when q == 0.

Behaviour:
- All state updates on the rising edge of clk only. No combinational path from inputs to outputs. Latency is 1 cycle.
- Priority at each edge: rst > en > mode.
- Reset (rst=1 at an edge, regardless of en/mode):
  - q = RESET_VAL, qbar = ~RESET_VAL.
  - carry = 0.
  - zero = (RESET_VAL == 0).
- en=0 and rst=0: q, qbar, carry and zero all hold.
- en=1, mode encoding (q' = next q):
  - 000 HOLD: q' = q; carry holds.
  - 001 LOAD: q' = d; carry = 0.
  - 010 SHL: q' = {q[WIDTH-2:0], sin_l}; carry = q[WIDTH-1].
  - 011 SHR: q' = {sin_r, q[WIDTH-1:1]}; carry = q[0].
  - 100 ROL: q' = {q[WIDTH-2:0], q[WIDTH-1]}; carry = q[WIDTH-1].
  - 101 ROR: q' = {q[0], q[WIDTH-1:1]}; carry = q[0].
  - 110 INC: q' = q + 1 modulo 2^WIDTH; carry = 1 iff q was all ones (wrap to 0), else 0.
  - 111 DEC: q' = q - 1 modulo 2^WIDTH; carry = 1 iff q was 0 (wrap to all ones), else 0.
- Outputs qbar and zero:
  - qbar is registered alongside q and is never computed from q combinationally. Invariant: qbar == ~q in every cycle after the first edge.
  - zero = (q' == 0) on every enabled or reset edge; it holds when en=0.
- Arithmetic is unsigned; no saturation.
- Unknown/X on mode while en=1 is not a supported condition; the bench must not drive it.
- Reset mid-operation (e.g. during an INC run) discards the operation in that cycle; the next edge with rst=0 resumes from RESET_VAL.
- Power-up before the first reset edge: outputs undefined. The bench must apply rst for at least 1 edge.

Test Plan:
- WIDTH=8, RESET_VAL=8'hA5: assert rst 2 cycles with en=0 -> q=A5, qbar=5A, carry=0, zero=0. Then LOAD d=00 -> q=00, qbar=FF, zero=1.
- LOAD 8'h81, then SHL with sin_l=0 -> q=02, carry=1. Then SHR with sin_r=1 -> q=81, carry=0. Then ROR -> q=C0, carry=1. Then ROL -> q=81, carry=1.
- LOAD 8'hFE, then INC for 3 cycles -> q=FF/carry=0, q=00/carry=1/zero=1, q=01/carry=0/zero=0. Then DEC twice -> q=00/zero=1, then q=FF/carry=1.
- en=0 with mode=INC for 4 cycles after q=3C -> q, qbar, carry and zero unchanged. Then en=1 HOLD -> q=3C, carry unchanged.
- rst=1 in the same cycle as en=1, mode=LOAD, d=77 -> q=RESET_VAL (A5), not 77, and carry=0.
- Random mode/d/sin sequences, 1000 cycles, against a reference model -> q, carry and zero match every cycle, and qbar == ~q every cycle.
